// File: rtl/rv_mem_pkg.sv
// ============================================================================
// Module      : rv_mem_pkg
// Description : Shared constants for the data-memory stage: opcodes, access
//               size codes, FSM state encoding and the access-size mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_mem_pkg;

    localparam logic [6:0] c_opc_load  = 7'b0000011;
    localparam logic [6:0] c_opc_store = 7'b0100011;

    // funct3[1:0] encodes the access size for both loads and stores
    localparam logic [1:0] c_sz_byte  = 2'd0;
    localparam logic [1:0] c_sz_half  = 2'd1;
    localparam logic [1:0] c_sz_word  = 2'd2;
    localparam logic [1:0] c_sz_dword = 2'd3;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;

    // Address bits that must be zero for a naturally aligned access
    function automatic logic [2:0] size_mask(input logic [1:0] sz);
        case (sz)
            c_sz_byte:  return 3'b000;
            c_sz_half:  return 3'b001;
            c_sz_word:  return 3'b011;
            default:    return 3'b111;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
// Module      : load_extend
// Description : Combinational byte-lane select and sign/zero extension of a
//               64-bit RAM word for load writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extend
    import rv_mem_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] rdata
);

    logic [63:0] w_shifted;
    logic        w_signed;

    assign w_shifted = word >> {offset, 3'b000};
    assign w_signed  = ~funct3[2];

    always_comb begin
        rdata = '0;
        case (funct3[1:0])
            c_sz_byte:  rdata = {{56{w_signed & w_shifted[7]}},  w_shifted[7:0]};
            c_sz_half:  rdata = {{48{w_signed & w_shifted[15]}}, w_shifted[15:0]};
            c_sz_word:  rdata = {{32{w_signed & w_shifted[31]}}, w_shifted[31:0]};
            // funct3 7 has no unsigned doubleword load, so it returns zero
            c_sz_dword: rdata = funct3[2] ? 64'd0 : w_shifted;
            default:    rdata = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_stage.sv
// ============================================================================
// Module      : dmem_stage
// Description : RV64I load/store stage against an internal word RAM with a
//               valid/ready request and a one-cycle response pulse.
//               Optional macro DMEM_MISALIGN_CHECK_EN flags misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_stage
    import rv_mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] instruction,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        resp_valid,
    output logic [63:0] rdata,
    output logic        misalign
);

    localparam int         AW    = $clog2(DEPTH);
    localparam logic [3:0] c_lat = 4'(LATENCY);

    logic [1:0]    r_state, w_state_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [6:0]    r_opc;
    logic [2:0]    r_f3;
    logic [AW+2:0] r_addr;
    logic [63:0]   r_wdata;
    logic          r_resp_valid;
    logic [63:0]   r_rdata;
    logic          r_misalign;
    logic [63:0]   r_mem [DEPTH];

    logic          w_accept, w_last, w_is_load, w_is_store, w_is_mem, w_mis, w_we;
    logic [2:0]    w_mask, w_offset;
    logic [AW-1:0] w_idx;
    logic [63:0]   w_word, w_load_data, w_wd_sh, w_merged;
    logic [7:0]    w_be, w_be_sh;

    assign req_ready  = (r_state == c_st_idle);
    assign w_accept   = req_valid && req_ready;
    assign w_last     = (r_state == c_st_access) && (r_cnt == 4'd1);

    assign w_is_load  = (r_opc == c_opc_load);
    assign w_is_store = (r_opc == c_opc_store) && !r_f3[2];
    assign w_is_mem   = (w_is_load && (r_f3 != 3'd7)) || w_is_store;
    assign w_mask     = size_mask(r_f3[1:0]);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_mis    = w_is_mem && (|(r_addr[2:0] & w_mask));
    assign w_offset = r_addr[2:0];
`else
    assign w_mis    = 1'b0;
    assign w_offset = r_addr[2:0] & ~w_mask;
`endif

    assign w_idx  = r_addr[AW+2:3];
    assign w_word = r_mem[w_idx];

    load_extend u_load_extend (
        .word   (w_word),
        .offset (w_offset),
        .funct3 (r_f3),
        .rdata  (w_load_data)
    );

    // Store byte-merge: only the addressed lanes take new data
    always_comb begin
        w_be = 8'h00;
        case (r_f3[1:0])
            c_sz_byte:  w_be = 8'h01;
            c_sz_half:  w_be = 8'h03;
            c_sz_word:  w_be = 8'h0F;
            default:    w_be = 8'hFF;
        endcase
        w_be_sh  = w_be << w_offset;
        w_wd_sh  = r_wdata << {w_offset, 3'b000};
        w_merged = w_word;
        for (int i = 0; i < 8; i++) begin
            if (w_be_sh[i]) w_merged[8*i +: 8] = w_wd_sh[8*i +: 8];
        end
    end

    assign w_we = w_last && w_is_store && !w_mis;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = c_st_access;
                    w_cnt_nxt   = c_lat;
                end
            end
            c_st_access: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = c_st_resp;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_cnt        <= 4'd0;
            r_opc        <= '0;
            r_f3         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_resp_valid <= w_last;
            r_rdata      <= (w_last && w_is_load && !w_mis) ? w_load_data : 64'd0;
            r_misalign   <= w_last && w_mis;
            if (w_accept) begin
                r_opc   <= instruction[6:0];
                r_f3    <= instruction[14:12];
                r_addr  <= addr[AW+2:0];
                r_wdata <= wdata;
            end
        end
    end

    // RAM contents survive reset; w_we is low while reset holds the FSM idle
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_idx] <= w_merged;
    end

    assign resp_valid = r_resp_valid;
    assign rdata      = r_rdata;
    assign misalign   = r_misalign;

    logic w_unused;
    assign w_unused = &{1'b0, instruction[31:15], instruction[11:7], addr[63:AW+3]};

endmodule

`default_nettype wire
